// File: rtl/digdug_spattr_buffer_if.sv
// Bus bundle for the sprite attribute buffer: CPU access port, video fetch
// port and copy-engine status.
interface digdug_spattr_buffer_if;
   logic        CPU_CS;
   logic        CPU_WE;
   logic [8:0]  CPU_AD;
   logic [7:0]  CPU_DI;
   logic [7:0]  CPU_DO;
   logic        VBLK;
   logic        SPATRQ;
   logic [6:0]  SPATAD;
   logic [23:0] SPATDT;
   logic        SPATVL;
   logic        BUSY;
   logic        OVERRUN;

   modport master (
      output CPU_CS, CPU_WE, CPU_AD, CPU_DI, VBLK, SPATRQ, SPATAD,
      input  CPU_DO, SPATDT, SPATVL, BUSY, OVERRUN
   );

   modport slave (
      input  CPU_CS, CPU_WE, CPU_AD, CPU_DI, VBLK, SPATRQ, SPATAD,
      output CPU_DO, SPATDT, SPATVL, BUSY, OVERRUN
   );
endinterface

// File: rtl/digdug_spattr_buffer.sv
// Sprite attribute double buffer: CPU-owned live RAM (3 banks x 128 bytes),
// copied into the inactive 24-bit shadow on each vertical blank, then swapped.
module digdug_spattr_buffer (
   input  logic                         CLK48M,
   input  logic                         RESET_N,
   digdug_spattr_buffer_if.slave        bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_COPY = 2'd1,
      ST_SWAP = 2'd2
   } state_t;

   logic [7:0]  live0_mem  [0:127];
   logic [7:0]  live1_mem  [0:127];
   logic [7:0]  live2_mem  [0:127];
   logic [23:0] shad_a_mem [0:127];
   logic [23:0] shad_b_mem [0:127];

   state_t      state_q, state_d;
   logic [6:0]  ptr_q, ptr_d;
   logic        rd_done_q, rd_done_d;
   logic        act_q, act_d;
   logic        vblk_q, vblk_d;
   logic        pipe_vld_q, pipe_vld_d;
   logic [6:0]  pipe_ad_q, pipe_ad_d;
   logic [23:0] pipe_dat_q, pipe_dat_d;
   logic [7:0]  cpu_do_q, cpu_do_d;
   logic [23:0] spatdt_q, spatdt_d;
   logic        spatvl_q, spatvl_d;
   logic        busy_q, busy_d;
   logic        overrun_q, overrun_d;

   logic [1:0]  cpu_bank_s;
   logic [6:0]  cpu_idx_s;
   logic        cpu_wr_s;
   logic [7:0]  cpu_rd_byte_s;
   logic [23:0] copy_word_s;
   logic [23:0] vid_word_s;
   logic        vblk_rise_s;

   assign cpu_bank_s  = bus.CPU_AD[8:7];
   assign cpu_idx_s   = bus.CPU_AD[6:0];
   assign cpu_wr_s    = bus.CPU_CS & bus.CPU_WE;
   assign copy_word_s = {live2_mem[ptr_q], live1_mem[ptr_q], live0_mem[ptr_q]};
   assign vid_word_s  = act_q ? shad_b_mem[bus.SPATAD] : shad_a_mem[bus.SPATAD];
   assign vblk_rise_s = vblk_d & ~vblk_q;

   // CPU read mux; bank 3 is unmapped and reads as all ones
   always_comb begin
      cpu_rd_byte_s = 8'hFF;
      case (cpu_bank_s)
         2'd0:    cpu_rd_byte_s = live0_mem[cpu_idx_s];
         2'd1:    cpu_rd_byte_s = live1_mem[cpu_idx_s];
         2'd2:    cpu_rd_byte_s = live2_mem[cpu_idx_s];
         default: cpu_rd_byte_s = 8'hFF;
      endcase
   end

   // Copy engine next state; the copy reads the live RAM before any CPU write at the same edge
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      rd_done_d  = rd_done_q;
      act_d      = act_q;
      pipe_vld_d = 1'b0;
      pipe_ad_d  = pipe_ad_q;
      pipe_dat_d = pipe_dat_q;
      overrun_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (vblk_rise_s) begin
               state_d   = ST_COPY;
               ptr_d     = 7'd0;
               rd_done_d = 1'b0;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_COPY: begin
            overrun_d = vblk_rise_s;
            if (rd_done_q) begin
               state_d = ST_SWAP;
            end else begin
               pipe_vld_d = 1'b1;
               pipe_ad_d  = ptr_q;
               pipe_dat_d = copy_word_s;
               ptr_d      = ptr_q + 7'd1;
               if (ptr_q == 7'd127) begin
                  rd_done_d = 1'b1;
               end else begin
                  rd_done_d = 1'b0;
               end
            end
         end
         ST_SWAP: begin
            overrun_d = vblk_rise_s;
            act_d     = ~act_q;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Port-side next values: CPU read data and video fetch hold when idle
   always_comb begin
      vblk_d   = bus.VBLK;
      spatvl_d = bus.SPATRQ;
      if (bus.CPU_CS && !bus.CPU_WE) begin
         cpu_do_d = cpu_rd_byte_s;
      end else begin
         cpu_do_d = cpu_do_q;
      end
      if (bus.SPATRQ) begin
         spatdt_d = vid_word_s;
      end else begin
         spatdt_d = spatdt_q;
      end
   end

   // Control and output registers
   always_ff @(posedge CLK48M or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 7'd0;
         rd_done_q  <= 1'b0;
         act_q      <= 1'b0;
         vblk_q     <= 1'b0;
         pipe_vld_q <= 1'b0;
         pipe_ad_q  <= 7'd0;
         pipe_dat_q <= 24'd0;
         cpu_do_q   <= 8'd0;
         spatdt_q   <= 24'd0;
         spatvl_q   <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rd_done_q  <= rd_done_d;
         act_q      <= act_d;
         vblk_q     <= vblk_d;
         pipe_vld_q <= pipe_vld_d;
         pipe_ad_q  <= pipe_ad_d;
         pipe_dat_q <= pipe_dat_d;
         cpu_do_q   <= cpu_do_d;
         spatdt_q   <= spatdt_d;
         spatvl_q   <= spatvl_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
      end
   end

   // Live RAM: CPU writes, bank 3 discarded
   always_ff @(posedge CLK48M) begin
      if (cpu_wr_s) begin
         case (cpu_bank_s)
            2'd0:    live0_mem[cpu_idx_s] <= bus.CPU_DI;
            2'd1:    live1_mem[cpu_idx_s] <= bus.CPU_DI;
            2'd2:    live2_mem[cpu_idx_s] <= bus.CPU_DI;
            default: ;
         endcase
      end
   end

   // Shadow RAMs: the copy pipe always targets the shadow not served to video
   always_ff @(posedge CLK48M) begin
      if (pipe_vld_q) begin
         if (act_q) begin
            shad_a_mem[pipe_ad_q] <= pipe_dat_q;
         end else begin
            shad_b_mem[pipe_ad_q] <= pipe_dat_q;
         end
      end
   end

   assign bus.CPU_DO  = cpu_do_q;
   assign bus.SPATDT  = spatdt_q;
   assign bus.SPATVL  = spatvl_q;
   assign bus.BUSY    = busy_q;
   assign bus.OVERRUN = overrun_q;
endmodule

// File: tb/tb_digdug_spattr_buffer.sv
// Directed bench for the sprite attribute buffer: CPU access, copy timing,
// overrun, mid-copy coherency and reset abort.
module tb_digdug_spattr_buffer;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   k;

   digdug_spattr_buffer_if bus ();

   digdug_spattr_buffer dut (
      .CLK48M  (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cpu_wr(input logic [1:0] bank, input logic [6:0] idx, input logic [7:0] dat);
      bus.CPU_CS = 1'b1;
      bus.CPU_WE = 1'b1;
      bus.CPU_AD = {bank, idx};
      bus.CPU_DI = dat;
      @(negedge clk);
      bus.CPU_CS = 1'b0;
      bus.CPU_WE = 1'b0;
   endtask

   task automatic cpu_rd_chk(input logic [1:0] bank, input logic [6:0] idx,
                             input logic [7:0] exp, input string tag);
      bus.CPU_CS = 1'b1;
      bus.CPU_WE = 1'b0;
      bus.CPU_AD = {bank, idx};
      @(negedge clk);
      bus.CPU_CS = 1'b0;
      chk(tag, {24'd0, bus.CPU_DO}, {24'd0, exp});
   endtask

   task automatic vid_rd(input logic [6:0] idx, input logic [23:0] exp, input string tag);
      bus.SPATRQ = 1'b1;
      bus.SPATAD = idx;
      @(negedge clk);
      bus.SPATRQ = 1'b0;
      chk({tag, "_vl"}, {31'd0, bus.SPATVL}, 32'd1);
      chk(tag, {8'd0, bus.SPATDT}, {8'd0, exp});
      @(negedge clk);
      chk({tag, "_vl0"}, {31'd0, bus.SPATVL}, 32'd0);
   endtask

   // Raise VBLK for two sampling edges, then count cycles until BUSY drops
   task automatic full_copy(input string tag);
      bus.VBLK = 1'b1;
      @(negedge clk);
      chk({tag, "_busy_rise"}, {31'd0, bus.BUSY}, 32'd1);
      @(negedge clk);
      bus.VBLK = 1'b0;
      k = 1;
      while (bus.BUSY === 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_busy_len"}, k, 32'd130);
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      bus.CPU_CS = 1'b0;
      bus.CPU_WE = 1'b0;
      bus.CPU_AD = 9'd0;
      bus.CPU_DI = 8'd0;
      bus.VBLK   = 1'b0;
      bus.SPATRQ = 1'b0;
      bus.SPATAD = 7'd0;
      repeat (3) @(negedge clk);
      chk("rst_cpu_do",  {24'd0, bus.CPU_DO}, 32'd0);
      chk("rst_spatdt",  {8'd0, bus.SPATDT}, 32'd0);
      chk("rst_spatvl",  {31'd0, bus.SPATVL}, 32'd0);
      chk("rst_busy",    {31'd0, bus.BUSY}, 32'd0);
      chk("rst_overrun", {31'd0, bus.OVERRUN}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      cpu_wr(2'd0, 7'd5, 8'h11);
      cpu_wr(2'd1, 7'd5, 8'h22);
      cpu_wr(2'd2, 7'd5, 8'h33);
      cpu_wr(2'd0, 7'd3, 8'h30);
      cpu_wr(2'd1, 7'd3, 8'h31);
      cpu_wr(2'd2, 7'd3, 8'h32);
      cpu_rd_chk(2'd0, 7'd5, 8'h11, "rd_b0");
      cpu_rd_chk(2'd1, 7'd5, 8'h22, "rd_b1");
      cpu_rd_chk(2'd2, 7'd3, 8'h32, "rd_b2");
      cpu_rd_chk(2'd3, 7'd5, 8'hFF, "rd_b3");
      cpu_wr(2'd3, 7'd5, 8'hAA);
      repeat (3) @(negedge clk);
      chk("do_hold", {24'd0, bus.CPU_DO}, 32'h000000FF);
      cpu_rd_chk(2'd0, 7'd5, 8'h11, "b3wr_b0");
      cpu_rd_chk(2'd1, 7'd5, 8'h22, "b3wr_b1");
      cpu_rd_chk(2'd2, 7'd5, 8'h33, "b3wr_b2");

      // First copy fills shadow B, video then serves B
      full_copy("c1");
      vid_rd(7'd5, 24'h332211, "v1_idx5");
      vid_rd(7'd3, 24'h323130, "v1_idx3");

      // Second copy: mid-copy write behind the pointer, plus an ignored VBLK rise
      bus.VBLK = 1'b1;
      @(negedge clk);
      chk("c2_busy_rise", {31'd0, bus.BUSY}, 32'd1);
      @(negedge clk);
      bus.VBLK = 1'b0;
      repeat (8) @(negedge clk);
      cpu_wr(2'd0, 7'd3, 8'h99);
      repeat (39) @(negedge clk);
      bus.VBLK = 1'b1;
      @(negedge clk);
      chk("ovr_pulse", {31'd0, bus.OVERRUN}, 32'd1);
      bus.VBLK = 1'b0;
      @(negedge clk);
      chk("ovr_one_cycle", {31'd0, bus.OVERRUN}, 32'd0);
      k = 51;
      while (bus.BUSY === 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("c2_no_restart", k, 32'd130);
      vid_rd(7'd3, 24'h323130, "v2_old3");
      vid_rd(7'd5, 24'h332211, "v2_idx5");

      // Third copy aborted by reset at ptr 64; shadow A must stay active
      bus.VBLK = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.VBLK = 1'b0;
      repeat (63) @(negedge clk);
      chk("c3_busy_mid", {31'd0, bus.BUSY}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cpu_do",  {24'd0, bus.CPU_DO}, 32'd0);
      chk("mid_rst_spatdt",  {8'd0, bus.SPATDT}, 32'd0);
      chk("mid_rst_spatvl",  {31'd0, bus.SPATVL}, 32'd0);
      chk("mid_rst_busy",    {31'd0, bus.BUSY}, 32'd0);
      chk("mid_rst_overrun", {31'd0, bus.OVERRUN}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vid_rd(7'd3, 24'h323130, "rst_old3");
      vid_rd(7'd5, 24'h332211, "rst_idx5");
      cpu_rd_chk(2'd0, 7'd3, 8'h99, "rst_live_kept");

      // Fourth copy completes and publishes the mid-copy write
      full_copy("c4");
      vid_rd(7'd3, 24'h323199, "v4_new3");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
